// File: rtl/hs_cmd_pkg.sv
// ----------------------------------------------------------------------------
// hs_cmd_pkg
// Shared definitions for the host-side command-slot scheduler:
//   - default slot count and slot index width
//   - scheduler FSM state encoding
//   - completion error codes reported on cmpl_err
// ----------------------------------------------------------------------------
package hs_cmd_pkg;

    localparam int unsigned C_NSLOT  = 32;
    localparam int unsigned C_SLOT_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_REQ,
        S_WAIT,
        S_CMPL
    } sched_state_t;

    typedef enum logic [1:0] {
        E_OK   = 2'b00,
        E_DEV  = 2'b01,
        E_TMO  = 2'b10,
        E_LINK = 2'b11
    } cmpl_err_t;

endpackage

// File: rtl/hs_cmd_sched_rr_arb.sv
// ----------------------------------------------------------------------------
// hs_rr_arb
// Combinational rotating-priority encoder. Grants the lowest set bit of req
// whose index is >= ptr; if there is none, wraps and grants the lowest set
// bit overall.
// Ports:
//   req      in   C_NSLOT   request bitmap
//   ptr      in   C_SLOT_W  highest-priority index this cycle
//   gnt_idx  out  C_SLOT_W  granted index (0 when gnt_vld is low)
//   gnt_vld  out  1         at least one request present
// ----------------------------------------------------------------------------
module hs_rr_arb #(
    parameter int unsigned C_NSLOT  = hs_cmd_pkg::C_NSLOT,
    parameter int unsigned C_SLOT_W = hs_cmd_pkg::C_SLOT_W
) (
    input  logic [C_NSLOT-1:0]  req,
    input  logic [C_SLOT_W-1:0] ptr,
    output logic [C_SLOT_W-1:0] gnt_idx,
    output logic                gnt_vld
);

    int idx;

    // Walk the slots in priority order starting at ptr; the first hit wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int i = 0; i < int'(C_NSLOT); i++) begin
            idx = int'(ptr) + i;
            if (idx >= int'(C_NSLOT)) begin
                idx = idx - int'(C_NSLOT);
            end
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = C_SLOT_W'(idx);
            end
        end
    end

endmodule

// File: rtl/hs_cmd_sched.sv
// ----------------------------------------------------------------------------
// hs_cmd_sched
// Command-slot scheduler for the SATA host-side command path. Collects
// per-slot issue pulses, round-robin selects one pending slot, hands it to
// the command interface and waits for completion, timeout or link loss.
// One completion record is reported per slot.
// Ports:
//   sys_clk     in   clock
//   sys_rst     in   synchronous active-high reset
//   PhyReady    in   link up; scheduling only while high
//   slot_issue  in   per-slot issue pulses
//   slot_pend   out  pending slot bitmap
//   cmd_req     out  request level to the command interface, held until cmd_ack
//   cmd_ack     in   command interface accepted cmd_slot
//   cmd_slot    out  slot in flight (latched in ARB)
//   cmd_done    in   in-flight command finished (pulse)
//   cmd_err     in   device error, qualifies cmd_done
//   cmpl_valid  out  completion pulse
//   cmpl_slot   out  completed slot
//   cmpl_err    out  00 ok, 01 device err, 10 timeout, 11 link lost
//   sched_idle  out  FSM in IDLE
// ----------------------------------------------------------------------------
module hs_cmd_sched #(
    parameter int unsigned        C_NSLOT  = hs_cmd_pkg::C_NSLOT,
    parameter int unsigned        C_SLOT_W = hs_cmd_pkg::C_SLOT_W,
    parameter int unsigned        C_TMO_W  = 24,
    parameter logic [C_TMO_W-1:0] C_TMO    = 24'hFFFFFF
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                PhyReady,
    input  logic [C_NSLOT-1:0]  slot_issue,
    output logic [C_NSLOT-1:0]  slot_pend,
    output logic                cmd_req,
    input  logic                cmd_ack,
    output logic [C_SLOT_W-1:0] cmd_slot,
    input  logic                cmd_done,
    input  logic                cmd_err,
    output logic                cmpl_valid,
    output logic [C_SLOT_W-1:0] cmpl_slot,
    output logic [1:0]          cmpl_err,
    output logic                sched_idle
);

    import hs_cmd_pkg::*;

    localparam logic [C_TMO_W-1:0]  TMO_LAST  = C_TMO - C_TMO_W'(1);
    localparam logic [C_SLOT_W-1:0] SLOT_LAST = C_SLOT_W'(C_NSLOT - 1);

    sched_state_t          state_q, state_d;
    logic [C_NSLOT-1:0]    pend_q;
    logic [C_NSLOT-1:0]    clr;
    logic [C_SLOT_W-1:0]   ptr_q;
    logic [C_SLOT_W-1:0]   slot_q;
    logic [C_TMO_W-1:0]    timer_q;
    cmpl_err_t             err_q, err_d;
    logic                  lat_slot, tmr_clr, tmr_inc, err_ld;
    logic [C_SLOT_W-1:0]   gnt_idx;
    logic                  gnt_vld;

    hs_rr_arb #(
        .C_NSLOT  (C_NSLOT),
        .C_SLOT_W (C_SLOT_W)
    ) u_arb (
        .req     (pend_q),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Next-state and control strobes. Link loss outranks every other event.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a variable unassigned and no latch appears.
        state_d  = state_q;
        lat_slot = 1'b0;
        tmr_clr  = 1'b0;
        tmr_inc  = 1'b0;
        err_ld   = 1'b0;
        err_d    = E_OK;
        case (state_q)
            S_IDLE: begin
                if (PhyReady && |pend_q) state_d = S_ARB;
            end
            S_ARB: begin
                if (gnt_vld) begin
                    lat_slot = 1'b1;
                    state_d  = S_REQ;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_REQ: begin
                if (!PhyReady) begin
                    err_ld  = 1'b1;
                    err_d   = E_LINK;
                    state_d = S_CMPL;
                end else if (cmd_ack) begin
                    tmr_clr = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!PhyReady) begin
                    err_ld  = 1'b1;
                    err_d   = E_LINK;
                    state_d = S_CMPL;
                end else if (cmd_done) begin
                    err_ld  = 1'b1;
                    err_d   = cmd_err ? E_DEV : E_OK;
                    state_d = S_CMPL;
                end else if (timer_q == TMO_LAST) begin
                    err_ld  = 1'b1;
                    err_d   = E_TMO;
                    state_d = S_CMPL;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            S_CMPL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One-hot clear of the completing slot; applied after the issue OR, so a
    // same-cycle re-issue of that slot is dropped.
    always_comb begin
        clr = '0;
        if (state_q == S_CMPL) clr[slot_q] = 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (sys_rst) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: the pending bitmap is reset along with the control state; a
        // stale pending bit after reset would schedule a slot nobody issued.
        if (sys_rst) begin
            pend_q  <= '0;
            ptr_q   <= '0;
            slot_q  <= '0;
            timer_q <= '0;
            err_q   <= E_OK;
        end else begin
            pend_q <= (pend_q | slot_issue) & ~clr;
            if (lat_slot) slot_q <= gnt_idx;
            if (tmr_clr)      timer_q <= '0;
            else if (tmr_inc) timer_q <= timer_q + C_TMO_W'(1);
            if (err_ld) err_q <= err_d;
            if (state_q == S_CMPL) begin
                ptr_q <= (slot_q == SLOT_LAST) ? '0 : slot_q + C_SLOT_W'(1);
            end
        end
    end

    // cmd_req is gated by PhyReady so a link drop withdraws it immediately.
    assign cmd_req    = (state_q == S_REQ) && PhyReady;
    assign cmd_slot   = slot_q;
    assign cmpl_valid = (state_q == S_CMPL);
    assign cmpl_slot  = cmpl_valid ? slot_q : '0;
    assign cmpl_err   = cmpl_valid ? err_q : E_OK;
    assign sched_idle = (state_q == S_IDLE);
    assign slot_pend  = pend_q;

endmodule

// File: tb/tb_hs_cmd_sched.sv
// ----------------------------------------------------------------------------
// tb_hs_cmd_sched
// Directed self-checking bench for hs_cmd_sched (timeout shortened to 16).
// Inputs are driven 1 time unit after the rising edge; registered outputs are
// read at the same point, before any input changes in that cycle.
// ----------------------------------------------------------------------------
module tb_hs_cmd_sched;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        PhyReady = 1'b1;
    logic [31:0] slot_issue = '0;
    logic [31:0] slot_pend;
    logic        cmd_req;
    logic        cmd_ack = 1'b0;
    logic [4:0]  cmd_slot;
    logic        cmd_done = 1'b0;
    logic        cmd_err = 1'b0;
    logic        cmpl_valid;
    logic [4:0]  cmpl_slot;
    logic [1:0]  cmpl_err;
    logic        sched_idle;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    hs_cmd_sched #(
        .C_NSLOT  (32),
        .C_SLOT_W (5),
        .C_TMO_W  (24),
        .C_TMO    (24'd16)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .PhyReady   (PhyReady),
        .slot_issue (slot_issue),
        .slot_pend  (slot_pend),
        .cmd_req    (cmd_req),
        .cmd_ack    (cmd_ack),
        .cmd_slot   (cmd_slot),
        .cmd_done   (cmd_done),
        .cmd_err    (cmd_err),
        .cmpl_valid (cmpl_valid),
        .cmpl_slot  (cmpl_slot),
        .cmpl_err   (cmpl_err),
        .sched_idle (sched_idle)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] mask);
        slot_issue = mask;
        tick();
        slot_issue = '0;
    endtask

    // Bounded wait for cmd_req; the caller checks cmd_req afterwards.
    task automatic wait_req();
        for (int i = 0; i < 200; i++) begin
            if (cmd_req) break;
            tick();
        end
    endtask

    // Ack ack_dly cycles after the request cycle, done done_dly cycles after
    // ack. Returns in the cycle after cmd_done (the expected CMPL cycle).
    task automatic serve(input int ack_dly, input int done_dly, input logic err);
        repeat (ack_dly) tick();
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        repeat (done_dly - 1) tick();
        cmd_done = 1'b1;
        cmd_err  = err;
        tick();
        cmd_done = 1'b0;
        cmd_err  = 1'b0;
    endtask

    initial begin
        int n, m;
        logic any;

        // Reset values
        repeat (3) tick();
        check("rst_pend", slot_pend, 32'h0);
        check("rst_idle", sched_idle, 1);
        check("rst_req", cmd_req, 0);
        check("rst_slot", cmd_slot, 0);
        check("rst_cvalid", cmpl_valid, 0);
        check("rst_cslot", cmpl_slot, 0);
        check("rst_cerr", cmpl_err, 0);
        sys_rst = 1'b0;
        tick();

        // 1: slots 0 and 4, latency and normal completion
        n = cyc;
        issue(32'h0000_0011);
        check("t1_pend", slot_pend, 32'h11);
        check("t1_idle_n1", sched_idle, 1);
        tick();
        check("t1_arb_n2", sched_idle, 0);
        check("t1_noreq_n2", cmd_req, 0);
        tick();
        check("t1_req_n3", cmd_req, 1);
        check("t1_lat", cyc - n, 3);
        check("t1_slot0", cmd_slot, 0);
        serve(2, 5, 1'b0);
        m = cyc - 1;
        check("t1_cv0", cmpl_valid, 1);
        check("t1_cs0", cmpl_slot, 0);
        check("t1_ce0", cmpl_err, 0);
        wait_req();
        check("t1_req2", cmd_req, 1);
        check("t1_lat_done_req", cyc - m, 4);
        check("t1_slot4", cmd_slot, 4);
        serve(2, 5, 1'b0);
        check("t1_cv4", cmpl_valid, 1);
        check("t1_cs4", cmpl_slot, 4);
        check("t1_ce4", cmpl_err, 0);
        tick();
        check("t1_pend_end", slot_pend, 32'h0);
        tick();
        check("t1_idle_end", sched_idle, 1);

        // 2: round robin from ptr=5 over slots 0, 5, 31
        issue(32'h8000_0021);
        wait_req();
        check("t2_slot_a", cmd_slot, 5);
        serve(1, 2, 1'b0);
        check("t2_cs_a", cmpl_slot, 5);
        wait_req();
        check("t2_slot_b", cmd_slot, 31);
        serve(1, 2, 1'b0);
        check("t2_cs_b", cmpl_slot, 31);
        wait_req();
        check("t2_slot_c", cmd_slot, 0);
        serve(1, 2, 1'b0);
        check("t2_cs_c", cmpl_slot, 0);
        check("t2_cv_c", cmpl_valid, 1);

        // 3: timeout. Timer is 0 in the first WAIT cycle and hits 15 in the
        // 16th; the completion is reported the cycle after (ack cycle + 17).
        issue(32'h0000_0200);
        wait_req();
        check("t3_slot", cmd_slot, 9);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        any = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            any |= cmpl_valid;
            tick();
        end
        check("t3_no_early_cmpl", any, 0);
        check("t3_cv", cmpl_valid, 1);
        check("t3_cs", cmpl_slot, 9);
        check("t3_ce", cmpl_err, 2'b10);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        any = 1'b0;
        repeat (6) begin
            any |= cmpl_valid | cmd_req;
            tick();
        end
        check("t3_late_done_ignored", any, 0);
        check("t3_idle", sched_idle, 1);
        check("t3_pend", slot_pend, 32'h0);

        // 4: link loss in WAIT with slots 1, 2 pending (ptr=10 wraps to 1)
        issue(32'h0000_0006);
        wait_req();
        check("t4_slot1", cmd_slot, 1);
        tick();
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        tick();
        PhyReady = 1'b0;
        tick();
        check("t4_cv", cmpl_valid, 1);
        check("t4_cs", cmpl_slot, 1);
        check("t4_ce", cmpl_err, 2'b11);
        check("t4_req_low", cmd_req, 0);
        tick();
        check("t4_pend", slot_pend, 32'h4);
        any = 1'b0;
        repeat (8) begin
            any |= cmd_req | ~sched_idle;
            tick();
        end
        check("t4_held_off", any, 0);
        PhyReady = 1'b1;
        wait_req();
        check("t4_req2", cmd_req, 1);
        check("t4_slot2", cmd_slot, 2);
        serve(0, 1, 1'b1);
        check("t4_cs2", cmpl_slot, 2);
        check("t4_ce2_dev", cmpl_err, 2'b01);

        // 5: re-issue of the completing slot is dropped, other issue kept
        issue(32'h0000_0008);
        wait_req();
        check("t5_slot3", cmd_slot, 3);
        serve(0, 1, 1'b0);
        check("t5_cs3", cmpl_slot, 3);
        issue(32'h0000_0088);
        check("t5_pend", slot_pend, 32'h80);
        wait_req();
        check("t5_slot7", cmd_slot, 7);
        serve(0, 1, 1'b0);
        check("t5_cs7", cmpl_slot, 7);

        // 6: reset in WAIT, then pointer back at 0 (5 wins over 20)
        issue(32'h0000_1000);
        wait_req();
        check("t6_slot12", cmd_slot, 12);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        repeat (2) tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check("t6_idle", sched_idle, 1);
        check("t6_cv", cmpl_valid, 0);
        check("t6_pend", slot_pend, 32'h0);
        check("t6_req", cmd_req, 0);
        check("t6_slot", cmd_slot, 0);
        check("t6_ce", cmpl_err, 0);
        any = 1'b0;
        repeat (4) begin
            any |= cmpl_valid;
            tick();
        end
        check("t6_no_cmpl", any, 0);
        issue(32'h0010_0020);
        wait_req();
        check("t6_req_after", cmd_req, 1);
        check("t6_ptr_reset", cmd_slot, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
